cpu_fetch_unit: RTL and testbench
=================================

# cpu_fetch_unit

Responder side of the fetch interface: consumes the request signals (pc, jump, jump_pc, exception, TLB writes) and produces the response signals (tlb_hit, instr, cache_hit, next_pc). Holds a 4-entry fully-associative iTLB and an 8-line direct-mapped instruction cache with a single-outstanding refill FSM toward the memory port. Sits between the PC register and decode; decode redirects arrive via jump/jump_pc.

## Interface
- VA_W, `VIRTUAL_ADDR_WIDTH (32): virtual address width
- PA_W, `PHYSICAL_ADDR_WIDTH (20): physical address width
- INSTR_W, `INSTR_WIDTH (32): instruction width
- EXC_VECTOR, 32'h0000_1000: next_pc on exception
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- tlb_enable  in  1  1: translate pc through iTLB; 0: PA = pc[PA_W-1:0]
- tlb_write  in  1  insert iTLB entry this cycle
- tlb_addr  in  VA_W  virtual address of entry (VPN = [VA_W-1:12])
- tlb_data  in  PA_W  physical address of entry (PPN = [PA_W-1:12])
- pc  in  VA_W  current fetch address (word aligned)
- jump  in  1  redirect from decode
- jump_pc  in  VA_W  redirect target
- exception  in  1  redirect to EXC_VECTOR
- icache_flush  in  1  invalidate all cache lines
- tlb_hit  out  1  translation valid (forced 1 when tlb_enable=0)
- instr  out  INSTR_W  fetched instruction, NOP when cache_hit=0
- cache_hit  out  1  instr valid this cycle
- next_pc  out  VA_W  PC for next cycle
- mem_req  out  1  line read request
- mem_addr  out  PA_W  line-aligned physical address (low 4 bits 0)
- mem_ready  in  1  memory accepts request
- mem_valid  in  1  line data returned
- mem_data  in  128  line data, word 0 in [31:0]

## Operation
- iTLB: 4 entries {valid, VPN, PPN}; combinational lookup on pc. tlb_write: if VPN matches a valid entry, overwrite it; else write at FIFO pointer, pointer += 1 mod 4. Write and lookup same cycle: lookup sees old contents.
- Cache geometry: 16-byte lines, index = PA[6:4], word = PA[3:2], tag = PA[PA_W-1:7]. One valid bit per line.
- cache_hit = tlb_hit & state==IDLE & valid[idx] & tag match. instr = selected word if hit, else NOP (32'h0000_0000).
- next_pc priority: exception -> EXC_VECTOR; jump -> jump_pc; cache_hit -> pc+4 (wraps mod 2^VA_W); else pc (stall).
- FSM states IDLE, REQ, WAIT:
  - IDLE -> REQ when tlb_hit & !cache_hit & !jump & !exception & !icache_flush; latch line address {PA[PA_W-1:4],4'b0}.
  - REQ: mem_req=1, mem_addr=latched; -> WAIT when mem_ready.
  - WAIT: on mem_valid write data, tag, valid bit unless drop flag set; -> IDLE.
- TLB miss (tlb_hit=0): no refill; stall; miss handling is outside this block.
- jump/exception during REQ/WAIT: refill is not cancelled; it completes and fills the line; next_pc still redirects.
- icache_flush: clears all valid bits on the edge. If state != IDLE, sets drop flag so the in-flight fill is discarded; flag clears on return to IDLE.

## Timing
- Reset: state IDLE, all valid bits 0, iTLB valid 0, FIFO pointer 0, drop flag 0, mem_req 0, mem_addr 0. Combinational outputs follow inputs (cache_hit 0 after reset).
- Hit: 0-cycle (combinational from pc).
- Miss, mem_ready=1 in REQ, mem_valid one cycle later: detect t0, REQ t1, WAIT t2, hit t3 (3 stall cycles).
- mem_req held high and mem_addr stable until mem_ready.
- tlb_write/flush take effect on the edge; visible next cycle.

## Structure
- cpu_fetch_pkg: state enum, NOP, LINE_BYTES, INDEX_BITS, PAGE_BITS constants.
- Sub-module cpu_itlb (entries, FIFO pointer, lookup/overwrite logic); cache array and FSM in cpu_fetch_unit.

## Test plan
- Reset, tlb_enable=0, pc=0x40 -> miss; mem_req at t1 with mem_addr=0x40; return line; t3 cache_hit=1, instr=word0, next_pc=0x44.
- tlb_write VPN 0x00010 -> PPN 0x05; pc=0x0001_0008, tlb_enable=1 -> tlb_hit=1, mem_addr=0x05000; unmapped pc -> tlb_hit=0, no mem_req, next_pc=pc.
- Five tlb_writes with distinct VPNs -> first entry evicted; rewrite of existing VPN changes PPN without moving pointer.
- jump=1 jump_pc=0x200 during WAIT -> next_pc=0x200; fill still completes, prior line hits later; exception+jump same cycle -> next_pc=0x1000.
- icache_flush in WAIT -> after mem_valid the line remains invalid, pc re-misses; flush in IDLE -> all hits drop to 0 next cycle.
- Hold mem_ready=0 for 5 cycles -> mem_req, mem_addr stable; reset asserted in WAIT -> IDLE, mem_req 0 next cycle, late mem_valid ignored.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// Shared types and geometry constants for the instruction fetch unit.
package cpu_fetch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP         = 32'h0000_0000;
   localparam int          LINE_BYTES  = 16;
   localparam int          INDEX_BITS  = 3;
   localparam int          PAGE_BITS   = 12;
   localparam int          OFFSET_BITS = $clog2(LINE_BYTES);
   localparam int          NUM_LINES   = 1 << INDEX_BITS;
   localparam int          TLB_ENTRIES = 4;

endpackage

// File: rtl/cpu_itlb.sv
// Four-entry fully-associative instruction TLB with FIFO replacement.
module cpu_itlb
   import cpu_fetch_pkg::*;
#(
   parameter int VA_W = 32,
   parameter int PA_W = 20
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_tlb_write,
   input  logic [VA_W-1:0] i_tlb_addr,
   input  logic [PA_W-1:0] i_tlb_data,
   input  logic [VA_W-1:0] i_va,
   output logic            o_hit,
   output logic [PA_W-1:0] o_pa
);

   localparam int VPN_W = VA_W - PAGE_BITS;
   localparam int PPN_W = PA_W - PAGE_BITS;
   localparam int PTR_W = $clog2(TLB_ENTRIES);

   logic [TLB_ENTRIES-1:0] r_valid;
   logic [VPN_W-1:0]       r_vpn [TLB_ENTRIES];
   logic [PPN_W-1:0]       r_ppn [TLB_ENTRIES];
   logic [PTR_W-1:0]       r_ptr;

   logic                   w_hit;
   logic [PPN_W-1:0]       w_ppn;
   logic                   w_wr_match;
   logic [PTR_W-1:0]       w_wr_match_idx;
   logic [PTR_W-1:0]       w_wr_sel;
   logic                   w_unused;

   assign w_unused = ^{i_tlb_addr[PAGE_BITS-1:0], i_tlb_data[PAGE_BITS-1:0]};

   // Lookup and write-match search both run against the pre-edge contents
   always_comb begin
      w_hit          = 1'b0;
      w_ppn          = '0;
      w_wr_match     = 1'b0;
      w_wr_match_idx = '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
         if (r_valid[i] && (r_vpn[i] == i_va[VA_W-1:PAGE_BITS])) begin
            w_hit = 1'b1;
            w_ppn = r_ppn[i];
         end
         if (r_valid[i] && (r_vpn[i] == i_tlb_addr[VA_W-1:PAGE_BITS])) begin
            w_wr_match     = 1'b1;
            w_wr_match_idx = PTR_W'(i);
         end
      end
   end

   assign w_wr_sel = w_wr_match ? w_wr_match_idx : r_ptr;
   assign o_hit    = w_hit;
   assign o_pa     = {w_ppn, i_va[PAGE_BITS-1:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= '0;
         r_ptr   <= '0;
      end else if (i_tlb_write && !w_wr_match) begin
         r_valid[r_ptr] <= 1'b1;
         r_ptr          <= r_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_tlb_write) begin
         r_vpn[w_wr_sel] <= i_tlb_addr[VA_W-1:PAGE_BITS];
         r_ppn[w_wr_sel] <= i_tlb_data[PA_W-1:PAGE_BITS];
      end
   end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Fetch responder: iTLB translation, 8-line direct-mapped I-cache and a
// single-outstanding line refill toward the memory port.
module cpu_fetch_unit
   import cpu_fetch_pkg::*;
#(
   parameter int              VA_W       = 32,
   parameter int              PA_W       = 20,
   parameter int              INSTR_W    = 32,
   parameter logic [VA_W-1:0] EXC_VECTOR = 32'h0000_1000
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      tlb_enable,
   input  logic                      tlb_write,
   input  logic [VA_W-1:0]           tlb_addr,
   input  logic [PA_W-1:0]           tlb_data,
   input  logic [VA_W-1:0]           pc,
   input  logic                      jump,
   input  logic [VA_W-1:0]           jump_pc,
   input  logic                      exception,
   input  logic                      icache_flush,
   output logic                      tlb_hit,
   output logic [INSTR_W-1:0]        instr,
   output logic                      cache_hit,
   output logic [VA_W-1:0]           next_pc,
   output logic                      mem_req,
   output logic [PA_W-1:0]           mem_addr,
   input  logic                      mem_ready,
   input  logic                      mem_valid,
   input  logic [LINE_BYTES*8-1:0]   mem_data
);

   localparam int TAG_W = PA_W - OFFSET_BITS - INDEX_BITS;
   localparam int WORDS = (LINE_BYTES * 8) / INSTR_W;
   localparam int WSEL_W = $clog2(WORDS);

   fetch_state_t           r_state;
   logic [PA_W-1:0]        r_line_addr;
   logic                   r_drop;
   logic [NUM_LINES-1:0]   r_line_valid;
   logic [TAG_W-1:0]       r_tag  [NUM_LINES];
   logic [INSTR_W-1:0]     r_data [NUM_LINES][WORDS];

   logic                   w_itlb_hit;
   logic [PA_W-1:0]        w_itlb_pa;
   logic [PA_W-1:0]        w_pa;
   logic [INDEX_BITS-1:0]  w_idx;
   logic [WSEL_W-1:0]      w_word;
   logic [TAG_W-1:0]       w_tag;
   logic                   w_start;
   logic                   w_fill_done;
   logic [INDEX_BITS-1:0]  w_fill_idx;
   logic                   w_unused;

   cpu_itlb #(
      .VA_W (VA_W),
      .PA_W (PA_W)
   ) u_itlb (
      .clk         (clk),
      .reset       (reset),
      .i_tlb_write (tlb_write),
      .i_tlb_addr  (tlb_addr),
      .i_tlb_data  (tlb_data),
      .i_va        (pc),
      .o_hit       (w_itlb_hit),
      .o_pa        (w_itlb_pa)
   );

   assign w_pa     = tlb_enable ? w_itlb_pa : pc[PA_W-1:0];
   assign tlb_hit  = !tlb_enable || w_itlb_hit;
   assign w_idx    = w_pa[OFFSET_BITS +: INDEX_BITS];
   assign w_word   = w_pa[OFFSET_BITS-1 -: WSEL_W];
   assign w_tag    = w_pa[PA_W-1 -: TAG_W];
   assign w_unused = ^w_pa[OFFSET_BITS-WSEL_W-1:0];

   assign cache_hit = tlb_hit && (r_state == ST_IDLE) && r_line_valid[w_idx]
                      && (r_tag[w_idx] == w_tag);
   assign instr     = cache_hit ? r_data[w_idx][w_word] : INSTR_W'(NOP);

   always_comb begin
      if (exception)      next_pc = EXC_VECTOR;
      else if (jump)      next_pc = jump_pc;
      else if (cache_hit) next_pc = pc + VA_W'(4);
      else                next_pc = pc;
   end

   // A redirect or flush this cycle means the missing line is not wanted
   assign w_start     = (r_state == ST_IDLE) && tlb_hit && !cache_hit
                        && !jump && !exception && !icache_flush;
   assign w_fill_done = (r_state == ST_WAIT) && mem_valid;
   assign w_fill_idx  = r_line_addr[OFFSET_BITS +: INDEX_BITS];

   assign mem_req  = (r_state == ST_REQ);
   assign mem_addr = r_line_addr;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_line_addr  <= '0;
         r_drop       <= 1'b0;
         r_line_valid <= '0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_start) begin
               r_state     <= ST_REQ;
               r_line_addr <= {w_pa[PA_W-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            end
            ST_REQ:  if (mem_ready) r_state <= ST_WAIT;
            ST_WAIT: if (mem_valid) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         // A flush coinciding with the returning data also discards the fill
         if (w_fill_done && !r_drop && !icache_flush)
            r_line_valid[w_fill_idx] <= 1'b1;
         if (icache_flush)
            r_line_valid <= '0;

         if (w_fill_done)
            r_drop <= 1'b0;
         else if (icache_flush && (r_state != ST_IDLE))
            r_drop <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_fill_done) begin
         r_tag[w_fill_idx] <= r_line_addr[PA_W-1 -: TAG_W];
         for (int k = 0; k < WORDS; k++)
            r_data[w_fill_idx][k] <= mem_data[k*INSTR_W +: INSTR_W];
      end
   end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Directed bench for cpu_fetch_unit: vector table plus hand-built refill sequences.
module tb_cpu_fetch_unit;

   logic         clk = 1'b0;
   logic         reset, tlb_enable, tlb_write, jump, exception, icache_flush;
   logic         mem_ready, mem_valid;
   logic [31:0]  tlb_addr, pc, jump_pc;
   logic [19:0]  tlb_data;
   logic [127:0] mem_data;
   logic         tlb_hit, cache_hit, mem_req;
   logic [31:0]  instr, next_pc;
   logic [19:0]  mem_addr;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   cpu_fetch_unit dut (
      .clk          (clk),
      .reset        (reset),
      .tlb_enable   (tlb_enable),
      .tlb_write    (tlb_write),
      .tlb_addr     (tlb_addr),
      .tlb_data     (tlb_data),
      .pc           (pc),
      .jump         (jump),
      .jump_pc      (jump_pc),
      .exception    (exception),
      .icache_flush (icache_flush),
      .tlb_hit      (tlb_hit),
      .instr        (instr),
      .cache_hit    (cache_hit),
      .next_pc      (next_pc),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ready    (mem_ready),
      .mem_valid    (mem_valid),
      .mem_data     (mem_data)
   );

   typedef struct {
      logic        tlb_en;
      logic        exc;
      logic        jmp;
      logic [31:0] jpc;
      logic [31:0] pc;
      logic [31:0] e_npc;
      logic        e_tlb;
      logic        e_hit;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vecs[9];

   // Distinctive content for each word of the line at physical address la
   function automatic logic [31:0] wd(input logic [19:0] la, input int k);
      logic [3:0] kk;
      kk = 4'(k);
      return {8'hA5, kk, la};
   endfunction

   function automatic logic [127:0] line(input logic [19:0] la);
      return {wd(la, 3), wd(la, 2), wd(la, 1), wd(la, 0)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   // Caller has just applied miss inputs in an IDLE window (t0)
   task automatic refill(input logic [19:0] la);
      cyc(); #1;
      chk("refill mem_req", 32'(mem_req), 32'd1);
      chk("refill mem_addr", 32'(mem_addr), 32'(la));
      cyc();
      mem_valid = 1'b1;
      mem_data  = line(la);
      cyc();
      mem_valid = 1'b0;
   endtask

   task automatic tlbw(input logic [31:0] va, input logic [19:0] pa);
      cyc();
      tlb_write = 1'b1;
      tlb_addr  = va;
      tlb_data  = pa;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0000_00C0, 32'h0000_00C4, 1'b1, 1'b1, wd(20'h000C0, 0)};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0000_00CC, 32'h0000_00D0, 1'b1, 1'b1, wd(20'h000C0, 3)};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b1, wd(20'hFFFF0, 3)};
      vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0000_00D0, 32'h0000_00D0, 1'b1, 1'b0, 32'h0};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h200, 32'h0000_00C0, 32'h0000_0200, 1'b1, 1'b1, wd(20'h000C0, 0)};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h0000_00C0, 32'h0000_1000, 1'b1, 1'b1, wd(20'h000C0, 0)};
      vecs[6] = '{1'b0, 1'b1, 1'b1, 32'h300, 32'h0000_00D0, 32'h0000_1000, 1'b1, 1'b0, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,   32'h0000_01C0, 32'h0000_01C0, 1'b1, 1'b0, 32'h0};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h0000_00C0, 32'h0000_00C0, 1'b0, 1'b0, 32'h0};

      reset = 1'b1; tlb_enable = 1'b0; tlb_write = 1'b0; jump = 1'b0; exception = 1'b0;
      icache_flush = 1'b0; mem_ready = 1'b1; mem_valid = 1'b0; tlb_addr = '0; tlb_data = '0;
      pc = 32'h40; jump_pc = '0; mem_data = '0;

      // Reset state
      cyc(); cyc(); #1;
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst mem_addr", 32'(mem_addr), 32'd0);
      chk("rst cache_hit", 32'(cache_hit), 32'd0);
      chk("rst instr", instr, 32'd0);
      chk("rst tlb_hit bypass", 32'(tlb_hit), 32'd1);
      chk("rst next_pc", next_pc, 32'h40);
      tlb_enable = 1'b1; #1;
      chk("rst tlb empty", 32'(tlb_hit), 32'd0);
      tlb_enable = 1'b0;

      // Basic miss and refill, untranslated
      cyc(); reset = 1'b0; #1;
      chk("t0 cache_hit", 32'(cache_hit), 32'd0);
      chk("t0 next_pc stall", next_pc, 32'h40);
      refill(20'h00040); #1;
      chk("t3 cache_hit", 32'(cache_hit), 32'd1);
      chk("t3 instr w0", instr, wd(20'h00040, 0));
      chk("t3 next_pc", next_pc, 32'h44);
      pc = 32'h4C; #1;
      chk("t3 instr w3", instr, wd(20'h00040, 3));

      // Translated fetch
      cyc(); tlb_write = 1'b1; tlb_addr = 32'h0001_0000; tlb_data = 20'h05000;
      tlb_enable = 1'b1; pc = 32'h0001_0008; jump = 1'b1; #1;
      chk("tlb write-same-cycle old", 32'(tlb_hit), 32'd0);
      cyc(); tlb_write = 1'b0; jump = 1'b0; #1;
      chk("tlb hit", 32'(tlb_hit), 32'd1);
      refill(20'h05000); #1;
      chk("tlb fill hit", 32'(cache_hit), 32'd1);
      chk("tlb fill instr", instr, wd(20'h05000, 2));
      pc = 32'h0002_0000; #1;
      chk("unmapped tlb_hit", 32'(tlb_hit), 32'd0);
      chk("unmapped next_pc", next_pc, 32'h0002_0000);
      cyc(); #1;
      chk("unmapped no mem_req", 32'(mem_req), 32'd0);

      // FIFO eviction and in-place rewrite
      jump = 1'b1;
      tlbw(32'h0002_0000, 20'h02000);
      tlbw(32'h0003_0000, 20'h03000);
      tlbw(32'h0004_0000, 20'h04000);
      tlbw(32'h0005_0000, 20'h06000);
      cyc(); tlb_write = 1'b0; pc = 32'h0001_0008; #1;
      chk("fifo evicted first", 32'(tlb_hit), 32'd0);
      pc = 32'h0002_0000; #1;
      chk("fifo second kept", 32'(tlb_hit), 32'd1);
      tlbw(32'h0002_0000, 20'h07000);
      cyc(); tlb_write = 1'b0; jump = 1'b0; pc = 32'h0002_0010; #1;
      chk("rewrite hit", 32'(tlb_hit), 32'd1);
      refill(20'h07010); #1;
      chk("rewrite fill hit", 32'(cache_hit), 32'd1);
      jump = 1'b1;
      tlbw(32'h0006_0000, 20'h08000);
      cyc(); tlb_write = 1'b0; pc = 32'h0003_0000; #1;
      chk("rewrite ptr unmoved", 32'(tlb_hit), 32'd1);
      pc = 32'h0002_0000; #1;
      chk("ptr victim evicted", 32'(tlb_hit), 32'd0);

      // Jump during WAIT: redirect, fill still completes
      cyc(); tlb_enable = 1'b0; jump = 1'b0; pc = 32'h80;
      cyc(); #1;
      chk("jmp mem_addr", 32'(mem_addr), 32'h80);
      cyc(); jump = 1'b1; jump_pc = 32'h200; mem_valid = 1'b1; mem_data = line(20'h00080); #1;
      chk("jmp in WAIT next_pc", next_pc, 32'h200);
      cyc(); mem_valid = 1'b0; jump = 1'b0; #1;
      chk("jmp fill hit", 32'(cache_hit), 32'd1);
      chk("jmp fill instr", instr, wd(20'h00080, 0));

      // Flush during WAIT discards the fill
      cyc(); pc = 32'hC0;
      cyc(); #1;
      chk("flush mem_req", 32'(mem_req), 32'd1);
      cyc(); icache_flush = 1'b1;
      cyc(); icache_flush = 1'b0; mem_valid = 1'b1; mem_data = line(20'h000C0);
      cyc(); mem_valid = 1'b0; jump = 1'b1; #1;
      chk("flush dropped fill", 32'(cache_hit), 32'd0);
      chk("flush idle mem_req", 32'(mem_req), 32'd0);
      pc = 32'h80; #1;
      chk("flush cleared other", 32'(cache_hit), 32'd0);
      pc = 32'hC0; jump = 1'b0;
      refill(20'h000C0); #1;
      chk("refetch after drop", 32'(cache_hit), 32'd1);

      // Flush in IDLE
      cyc(); icache_flush = 1'b1; jump = 1'b1; #1;
      chk("idle flush same cycle", 32'(cache_hit), 32'd1);
      cyc(); icache_flush = 1'b0; #1;
      chk("idle flush next cycle", 32'(cache_hit), 32'd0);
      jump = 1'b0;
      refill(20'h000C0);
      pc = 32'hFFFF_FFF0;
      refill(20'hFFFF0);

      // Combinational vector table
      for (int i = 0; i < 9; i++) begin
         cyc();
         tlb_enable = vecs[i].tlb_en; exception = vecs[i].exc; jump = vecs[i].jmp;
         jump_pc = vecs[i].jpc; pc = vecs[i].pc; #1;
         chk($sformatf("vec%0d next_pc", i), next_pc, vecs[i].e_npc);
         chk($sformatf("vec%0d tlb_hit", i), 32'(tlb_hit), 32'(vecs[i].e_tlb));
         chk($sformatf("vec%0d cache_hit", i), 32'(cache_hit), 32'(vecs[i].e_hit));
         chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
         jump = 1'b1; exception = 1'b0;
      end

      // mem_ready held low, then reset in WAIT
      cyc(); jump = 1'b0; tlb_enable = 1'b0; pc = 32'h100; mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(); #1;
         chk($sformatf("hold%0d mem_req", i), 32'(mem_req), 32'd1);
         chk($sformatf("hold%0d mem_addr", i), 32'(mem_addr), 32'h100);
      end
      mem_ready = 1'b1;
      cyc(); #1;
      chk("wait mem_req low", 32'(mem_req), 32'd0);
      reset = 1'b1;
      cyc(); reset = 1'b0; jump = 1'b1; mem_valid = 1'b1; mem_data = line(20'h00100); #1;
      chk("reset in WAIT mem_req", 32'(mem_req), 32'd0);
      cyc(); mem_valid = 1'b0; #1;
      chk("late mem_valid ignored", 32'(cache_hit), 32'd0);
      chk("late mem_req", 32'(mem_req), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
